// File: rtl/cci_mpf_vtp_pt_arb_pkg.sv
// Shared types and round-robin helpers for the VTP page-table walk arbiter.
// Index types are sized for the largest supported requester count (8).
package cci_mpf_vtp_pt_arb_pkg;

  localparam int VTP_PT_ARB_MAX_REQ = 8;
  localparam int VTP_PT_ARB_IDX_W   = (VTP_PT_ARB_MAX_REQ > 1) ? $clog2(VTP_PT_ARB_MAX_REQ) : 1;

  typedef logic [35:0] t_tlb_4kb_va_page_idx;
  typedef logic [29:0] t_tlb_4kb_pa_page_idx;
  typedef logic [7:0]  t_cci_mpf_shim_vtp_pt_walk_meta;
  typedef logic [3:0]  t_cci_mpf_shim_vtp_req_tag;

  typedef logic [VTP_PT_ARB_IDX_W-1:0] t_vtp_pt_arb_req_idx;

  typedef enum logic [1:0] {
    ARB,
    ISSUE,
    SETTLE
  } t_vtp_pt_arb_state;

  // First set bit at or after ptr, scanning circularly over n entries.
  function automatic t_vtp_pt_arb_req_idx rr_pick(
    input logic [VTP_PT_ARB_MAX_REQ-1:0] valid,
    input t_vtp_pt_arb_req_idx           ptr,
    input int                            n
  );
    t_vtp_pt_arb_req_idx win;
    int c;
    win = '0;
    for (int k = VTP_PT_ARB_MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        c = int'(ptr) + k;
        if (c >= n) c = c - n;
        if (valid[c]) win = t_vtp_pt_arb_req_idx'(c);
      end
    end
    return win;
  endfunction

  function automatic t_vtp_pt_arb_req_idx rr_next(
    input t_vtp_pt_arb_req_idx idx,
    input int                  n
  );
    if (int'(idx) >= n - 1) return '0;
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/cci_mpf_prim_fifo_lutram.sv
// Small show-ahead FIFO with combinational head output; a full FIFO accepts
// an enqueue in the same cycle as a dequeue.
module cci_mpf_prim_fifo_lutram #(
  parameter int N_DATA_BITS = 32,
  parameter int N_ENTRIES   = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [N_DATA_BITS-1:0]           enq_data,
  input  logic                             enq_en,
  output logic                             not_full,
  output logic [N_DATA_BITS-1:0]           first,
  input  logic                             deq_en,
  output logic                             not_empty,
  output logic [$clog2(N_ENTRIES+1)-1:0]   count
);

  localparam int AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int CW = $clog2(N_ENTRIES + 1);

  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(N_ENTRIES - 1)) return '0;
    return p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (enq_en) mem[wr_ptr] <= enq_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq_en) wr_ptr <= ptr_inc(wr_ptr);
      if (deq_en) rd_ptr <= ptr_inc(rd_ptr);
      case ({enq_en, deq_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign first     = mem[rd_ptr];
  assign not_empty = (count != '0);
  assign not_full  = (count != CW'(N_ENTRIES));

endmodule

// File: rtl/cci_mpf_svc_vtp_pt_arb_rr.sv
// Combinational requester picker: round-robin, or requester-0 strict priority
// over round-robin when CCI_MPF_VTP_PT_ARB_PRIO_EN is defined.
module cci_mpf_svc_vtp_pt_arb_rr
  import cci_mpf_vtp_pt_arb_pkg::*;
#(
  parameter int N_REQUESTERS = 2
) (
  input  logic [N_REQUESTERS-1:0] valid,
  input  t_vtp_pt_arb_req_idx     ptr,
  output logic                    any,
  output t_vtp_pt_arb_req_idx     winner,
  output t_vtp_pt_arb_req_idx     next_ptr
);

  logic [VTP_PT_ARB_MAX_REQ-1:0] v;

  always_comb begin
    v = '0;
    v[N_REQUESTERS-1:0] = valid;
    any = |valid;
`ifdef CCI_MPF_VTP_PT_ARB_PRIO_EN
    if (valid[0]) begin
      // Priority grants do not consume a round-robin turn.
      winner   = '0;
      next_ptr = ptr;
    end else begin
      v[0]     = 1'b0;
      winner   = rr_pick(v, ptr, N_REQUESTERS);
      next_ptr = rr_next(winner, N_REQUESTERS);
    end
`else
    winner   = rr_pick(v, ptr, N_REQUESTERS);
    next_ptr = rr_next(winner, N_REQUESTERS);
`endif
  end

endmodule

// File: rtl/cci_mpf_svc_vtp_pt_walk_arb.sv
// Shares one VTP page-table walk service among N_REQUESTERS TLB clients.
// Optional CCI_MPF_VTP_PT_ARB_PRIO_EN gives requester 0 strict priority.
module cci_mpf_svc_vtp_pt_walk_arb
  import cci_mpf_vtp_pt_arb_pkg::*;
#(
  parameter int N_REQUESTERS    = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int DEBUG_MESSAGES  = 0
) (
  input  logic                                                          clk,
  input  logic                                                          reset_n,

  input  logic [N_REQUESTERS-1:0]                                       c_req_valid,
  output logic [N_REQUESTERS-1:0]                                       c_req_rdy,
  input  logic [N_REQUESTERS*$bits(t_tlb_4kb_va_page_idx)-1:0]           c_req_va,
  input  logic [N_REQUESTERS*$bits(t_cci_mpf_shim_vtp_pt_walk_meta)-1:0] c_req_meta,
  input  logic [N_REQUESTERS*$bits(t_cci_mpf_shim_vtp_req_tag)-1:0]      c_req_tag,

  output logic [N_REQUESTERS-1:0]                                       c_rsp_en,
  output t_tlb_4kb_va_page_idx                                          c_rsp_va,
  output t_tlb_4kb_pa_page_idx                                          c_rsp_pa,
  output t_cci_mpf_shim_vtp_pt_walk_meta                                c_rsp_meta,
  output t_cci_mpf_shim_vtp_req_tag                                     c_rsp_tag,
  output logic                                                          c_rsp_is_big_page,
  output logic                                                          c_rsp_not_present,

  output logic                                                          srv_reqEn,
  input  logic                                                          srv_reqRdy,
  output t_tlb_4kb_va_page_idx                                          srv_reqVA,
  output t_cci_mpf_shim_vtp_pt_walk_meta                                srv_reqMeta,
  output t_cci_mpf_shim_vtp_req_tag                                     srv_reqTag,

  input  logic                                                          srv_rspEn,
  input  t_tlb_4kb_va_page_idx                                          srv_rspVA,
  input  t_tlb_4kb_pa_page_idx                                          srv_rspPA,
  input  t_cci_mpf_shim_vtp_pt_walk_meta                                srv_rspMeta,
  input  t_cci_mpf_shim_vtp_req_tag                                     srv_rspTag,
  input  logic                                                          srv_rspIsBigPage,
  input  logic                                                          srv_rspNotPresent,

  output logic                                                          busy,
  output logic                                                          err_unexpected_rsp
);

  localparam int VA_W   = $bits(t_tlb_4kb_va_page_idx);
  localparam int META_W = $bits(t_cci_mpf_shim_vtp_pt_walk_meta);
  localparam int TAG_W  = $bits(t_cci_mpf_shim_vtp_req_tag);
  localparam int CW     = $clog2(MAX_OUTSTANDING + 1);

  // Trace messages are a simulation-only aid with no hardware counterpart.
  if (DEBUG_MESSAGES != 0) begin : g_debug
  end

  t_vtp_pt_arb_state              state;
  t_vtp_pt_arb_req_idx            rr_ptr;
  t_vtp_pt_arb_req_idx            win_idx;
  t_vtp_pt_arb_req_idx            win_next_ptr;
  logic                           win_any;
  logic                           grant;
  logic                           pop;
  logic                           fifo_not_full;
  logic                           fifo_not_empty;
  t_vtp_pt_arb_req_idx            fifo_first;
  logic [CW-1:0]                  fifo_count;
  logic                           busy_next;
  logic [N_REQUESTERS-1:0]        rsp_oh;
  t_tlb_4kb_va_page_idx           sel_va;
  t_cci_mpf_shim_vtp_pt_walk_meta sel_meta;
  t_cci_mpf_shim_vtp_req_tag      sel_tag;

  cci_mpf_svc_vtp_pt_arb_rr #(
    .N_REQUESTERS (N_REQUESTERS)
  ) picker (
    .valid    (c_req_valid),
    .ptr      (rr_ptr),
    .any      (win_any),
    .winner   (win_idx),
    .next_ptr (win_next_ptr)
  );

  cci_mpf_prim_fifo_lutram #(
    .N_DATA_BITS ($bits(t_vtp_pt_arb_req_idx)),
    .N_ENTRIES   (MAX_OUTSTANDING)
  ) route_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .enq_data  (win_idx),
    .enq_en    (grant),
    .not_full  (fifo_not_full),
    .first     (fifo_first),
    .deq_en    (pop),
    .not_empty (fifo_not_empty),
    .count     (fifo_count)
  );

  // A pop in the same cycle frees the slot a full FIFO needs for this grant.
  assign pop   = srv_rspEn & fifo_not_empty;
  assign grant = (state == ARB) & win_any & srv_reqRdy & (fifo_not_full | pop);

  assign busy_next = grant | (fifo_count > CW'(1)) | ((fifo_count == CW'(1)) & ~pop);

  always_comb begin
    c_req_rdy = '0;
    rsp_oh    = '0;
    sel_va    = '0;
    sel_meta  = '0;
    sel_tag   = '0;
    for (int i = 0; i < N_REQUESTERS; i++) begin
      if (int'(win_idx) == i) begin
        c_req_rdy[i] = grant;
        sel_va       = c_req_va[i*VA_W +: VA_W];
        sel_meta     = c_req_meta[i*META_W +: META_W];
        sel_tag      = c_req_tag[i*TAG_W +: TAG_W];
      end
      if (pop && (int'(fifo_first) == i)) rsp_oh[i] = 1'b1;
    end
  end

  // Request path: ARB grants, ISSUE pulses the service, SETTLE waits out srv_reqRdy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ARB;
      rr_ptr      <= '0;
      srv_reqEn   <= 1'b0;
      srv_reqVA   <= '0;
      srv_reqMeta <= '0;
      srv_reqTag  <= '0;
    end else begin
      srv_reqEn <= 1'b0;
      case (state)
        ARB: begin
          if (grant) begin
            state       <= ISSUE;
            srv_reqEn   <= 1'b1;
            rr_ptr      <= win_next_ptr;
            srv_reqVA   <= sel_va;
            srv_reqMeta <= sel_meta;
            srv_reqTag  <= sel_tag;
          end
        end
        ISSUE:   state <= SETTLE;
        SETTLE:  state <= ARB;
        default: state <= ARB;
      endcase
    end
  end

  // Response path: one-cycle registered steering to the FIFO head requester.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_rsp_en           <= '0;
      c_rsp_va           <= '0;
      c_rsp_pa           <= '0;
      c_rsp_meta         <= '0;
      c_rsp_tag          <= '0;
      c_rsp_is_big_page  <= 1'b0;
      c_rsp_not_present  <= 1'b0;
      busy               <= 1'b0;
      err_unexpected_rsp <= 1'b0;
    end else begin
      c_rsp_en <= rsp_oh;
      busy     <= busy_next;
      if (pop) begin
        c_rsp_va          <= srv_rspVA;
        c_rsp_pa          <= srv_rspPA;
        c_rsp_meta        <= srv_rspMeta;
        c_rsp_tag         <= srv_rspTag;
        c_rsp_is_big_page <= srv_rspIsBigPage;
        c_rsp_not_present <= srv_rspNotPresent;
      end
      if (srv_rspEn && !fifo_not_empty) err_unexpected_rsp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cci_mpf_svc_vtp_pt_walk_arb.sv
// Scoreboard bench for the VTP page-table walk arbiter (two requesters).
module tb_cci_mpf_svc_vtp_pt_walk_arb;
  import cci_mpf_vtp_pt_arb_pkg::*;

  localparam int N = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  c_req_valid;
  logic [1:0]  c_req_rdy;
  logic [71:0] c_req_va;
  logic [15:0] c_req_meta;
  logic [7:0]  c_req_tag;
  logic [1:0]  c_rsp_en;
  logic [35:0] c_rsp_va;
  logic [29:0] c_rsp_pa;
  logic [7:0]  c_rsp_meta;
  logic [3:0]  c_rsp_tag;
  logic        c_rsp_is_big_page, c_rsp_not_present;
  logic        srv_reqEn, srv_reqRdy;
  logic [35:0] srv_reqVA;
  logic [7:0]  srv_reqMeta;
  logic [3:0]  srv_reqTag;
  logic        srv_rspEn;
  logic [35:0] srv_rspVA;
  logic [29:0] srv_rspPA;
  logic [7:0]  srv_rspMeta;
  logic [3:0]  srv_rspTag;
  logic        srv_rspIsBigPage, srv_rspNotPresent;
  logic        busy, err_unexpected_rsp;

  logic [35:0] cva   [N];
  logic [7:0]  cmeta [N];
  logic [3:0]  ctag  [N];

  assign c_req_va   = {cva[1], cva[0]};
  assign c_req_meta = {cmeta[1], cmeta[0]};
  assign c_req_tag  = {ctag[1], ctag[0]};

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          idx;
    logic [35:0] va;
    logic [7:0]  meta;
    logic [3:0]  tag;
  } t_srv;

  typedef struct {
    logic [1:0]  en;
    logic [35:0] va;
    logic [29:0] pa;
    logic [7:0]  meta;
    logic [3:0]  tag;
  } t_exp;

  t_srv srv_q[$];
  t_exp exp_q[$];

  always #5 clk = ~clk;

  cci_mpf_svc_vtp_pt_walk_arb #(
    .N_REQUESTERS    (N),
    .MAX_OUTSTANDING (8),
    .DEBUG_MESSAGES  (0)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .c_req_valid        (c_req_valid),
    .c_req_rdy          (c_req_rdy),
    .c_req_va           (c_req_va),
    .c_req_meta         (c_req_meta),
    .c_req_tag          (c_req_tag),
    .c_rsp_en           (c_rsp_en),
    .c_rsp_va           (c_rsp_va),
    .c_rsp_pa           (c_rsp_pa),
    .c_rsp_meta         (c_rsp_meta),
    .c_rsp_tag          (c_rsp_tag),
    .c_rsp_is_big_page  (c_rsp_is_big_page),
    .c_rsp_not_present  (c_rsp_not_present),
    .srv_reqEn          (srv_reqEn),
    .srv_reqRdy         (srv_reqRdy),
    .srv_reqVA          (srv_reqVA),
    .srv_reqMeta        (srv_reqMeta),
    .srv_reqTag         (srv_reqTag),
    .srv_rspEn          (srv_rspEn),
    .srv_rspVA          (srv_rspVA),
    .srv_rspPA          (srv_rspPA),
    .srv_rspMeta        (srv_rspMeta),
    .srv_rspTag         (srv_rspTag),
    .srv_rspIsBigPage   (srv_rspIsBigPage),
    .srv_rspNotPresent  (srv_rspNotPresent),
    .busy               (busy),
    .err_unexpected_rsp (err_unexpected_rsp)
  );

  // Leaves time at posedge+1: registered outputs settled, inputs may change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_one(input int cl, input logic [35:0] va, input logic [7:0] meta,
                           input logic [3:0] tag);
    int   n;
    logic got;
    logic [1:0] oh;
    t_srv s;
    cva[cl] = va; cmeta[cl] = meta; ctag[cl] = tag;
    oh = 2'(1 << cl);
    c_req_valid = oh;
    n = 0; got = 1'b0;
    #1;
    while (!got && n < 20) begin
      if (c_req_rdy != 2'b00) got = 1'b1;
      else begin @(posedge clk); #2; n++; end
    end
    total++;
    if (c_req_rdy !== oh) begin
      bad++;
      $display("FAIL grant client%0d: c_req_rdy=%b required=%b", cl, c_req_rdy, oh);
    end
    step();
    c_req_valid = 2'b00;
    total++;
    if ({srv_reqEn, srv_reqVA, srv_reqMeta, srv_reqTag} !== {1'b1, va, meta, tag}) begin
      bad++;
      $display("FAIL srv_req client%0d: en=%b va=%h meta=%h tag=%h required en=1 va=%h meta=%h tag=%h",
               cl, srv_reqEn, srv_reqVA, srv_reqMeta, srv_reqTag, va, meta, tag);
    end
    if (got) begin
      s.idx = cl; s.va = va; s.meta = meta; s.tag = tag;
      srv_q.push_back(s);
    end
  endtask

  task automatic check_rsp();
    t_exp e;
    e = exp_q.pop_front();
    total++;
    if ({c_rsp_en, c_rsp_va, c_rsp_pa, c_rsp_meta, c_rsp_tag} !== {e.en, e.va, e.pa, e.meta, e.tag}) begin
      bad++;
      $display("FAIL rsp: en=%b va=%h pa=%h meta=%h tag=%h required en=%b va=%h pa=%h meta=%h tag=%h",
               c_rsp_en, c_rsp_va, c_rsp_pa, c_rsp_meta, c_rsp_tag, e.en, e.va, e.pa, e.meta, e.tag);
    end
  endtask

  // Drives the next in-order service response and pushes its expected routing.
  task automatic drive_rsp(input logic [29:0] pa);
    t_srv s;
    t_exp e;
    s = srv_q.pop_front();
    e.en = 2'(1 << s.idx); e.va = s.va; e.pa = pa; e.meta = s.meta; e.tag = s.tag;
    exp_q.push_back(e);
    srv_rspEn = 1'b1; srv_rspVA = s.va; srv_rspPA = pa;
    srv_rspMeta = s.meta; srv_rspTag = s.tag;
  endtask

  task automatic respond_next(input logic [29:0] pa);
    if (srv_q.size() == 0) begin
      total++; bad++;
      $display("FAIL respond: nothing outstanding in bench service model");
      return;
    end
    drive_rsp(pa);
    step();
    srv_rspEn = 1'b0;
    check_rsp();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    c_req_valid = '0; srv_reqRdy = 1'b1; srv_rspEn = 1'b0;
    srv_rspVA = '0; srv_rspPA = '0; srv_rspMeta = '0; srv_rspTag = '0;
    srv_rspIsBigPage = 1'b0; srv_rspNotPresent = 1'b0;
    for (int i = 0; i < N; i++) begin cva[i] = '0; cmeta[i] = '0; ctag[i] = '0; end
    step(); step();
    total++; if (c_req_rdy !== 2'b00) begin bad++; $display("FAIL reset_rdy: got %b required 00", c_req_rdy); end
    total++; if (srv_reqEn !== 1'b0) begin bad++; $display("FAIL reset_reqEn: got %b required 0", srv_reqEn); end
    total++; if (c_rsp_en !== 2'b00) begin bad++; $display("FAIL reset_rsp_en: got %b required 00", c_rsp_en); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    total++; if (err_unexpected_rsp !== 1'b0) begin bad++; $display("FAIL reset_err: got %b required 0", err_unexpected_rsp); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    issue_one(1, 36'h0_0001_2345, 8'h5A, 4'h3);
    step(); step();
    respond_next(30'h000A_BCDE);
    step();
    total++; if (c_rsp_en !== 2'b00) begin bad++; $display("FAIL single_rsp_pulse: got %b required 00", c_rsp_en); end
  endtask

  task automatic test_fairness();
    int order[6];
    int grants, n;
    t_srv s;
    logic [1:0] oh;
`ifdef CCI_MPF_VTP_PT_ARB_PRIO_EN
    order = '{0, 0, 0, 0, 0, 0};
`else
    order = '{0, 1, 0, 1, 0, 1};
`endif
    cva[0] = 36'h111; cmeta[0] = 8'h10; ctag[0] = 4'h1;
    cva[1] = 36'h222; cmeta[1] = 8'h21; ctag[1] = 4'h2;
    c_req_valid = 2'b11;
    grants = 0; n = 0;
    while (grants < 6 && n < 60) begin
      #1;
      if (c_req_rdy != 2'b00) begin
        oh = 2'(1 << order[grants]);
        total++;
        if (c_req_rdy !== oh) begin
          bad++;
          $display("FAIL fair_grant%0d: c_req_rdy=%b required=%b", grants, c_req_rdy, oh);
        end
        s.idx = order[grants]; s.va = cva[s.idx]; s.meta = cmeta[s.idx]; s.tag = ctag[s.idx];
        srv_q.push_back(s);
        grants++;
      end
      @(posedge clk); #1; n++;
    end
    c_req_valid = 2'b00;
    if (grants < 6) begin
      total++; bad++;
      $display("FAIL fair_timeout: grants=%0d required 6", grants);
    end
    step(); step();
    for (int i = 0; i < 6 && srv_q.size() > 0; i++) respond_next(30'h100 + 30'(i));
  endtask

  task automatic test_routing();
    issue_one(1, 36'h0_0000_0A01, 8'hA1, 4'h9);
    issue_one(0, 36'h0_0000_0B02, 8'hB2, 4'h5);
    issue_one(1, 36'h0_0000_0C03, 8'hC3, 4'hE);
    step(); step();
    respond_next(30'h0000_1111);
    respond_next(30'h0000_2222);
    respond_next(30'h0000_3333);
  endtask

  task automatic test_backpressure();
    int grants;
    t_srv s;
    cva[0] = 36'h0_0000_0777; cmeta[0] = 8'h77; ctag[0] = 4'h7;
    c_req_valid = 2'b01;
    grants = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (c_req_rdy != 2'b00) begin
        grants++;
        s.idx = 0; s.va = cva[0]; s.meta = cmeta[0]; s.tag = ctag[0];
        srv_q.push_back(s);
      end
      @(posedge clk); #1;
    end
    total++; if (grants !== 8) begin bad++; $display("FAIL bp_grants: got %0d required 8", grants); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy: got %b required 1", busy); end
    // Full FIFO with a pop this cycle must still grant.
    drive_rsp(30'h0000_4000);
    #1;
    total++;
    if (c_req_rdy !== 2'b01) begin
      bad++;
      $display("FAIL bp_full_pop_grant: c_req_rdy=%b required 01", c_req_rdy);
    end else begin
      s.idx = 0; s.va = cva[0]; s.meta = cmeta[0]; s.tag = ctag[0];
      srv_q.push_back(s);
    end
    @(posedge clk); #1;
    srv_rspEn = 1'b0;
    check_rsp();
    grants = 0;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (c_req_rdy != 2'b00) grants++;
      @(posedge clk); #1;
    end
    c_req_valid = 2'b00;
    total++; if (grants !== 0) begin bad++; $display("FAIL bp_extra_grants: got %0d required 0", grants); end
    for (int i = 0; i < 8 && srv_q.size() > 0; i++) respond_next(30'h0000_4001 + 30'(i));
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_busy_drained: got %b required 0", busy); end
  endtask

  task automatic test_error();
    srv_rspEn = 1'b1; srv_rspPA = 30'h3FFF_FFFF;
    step();
    srv_rspEn = 1'b0;
    total++; if (c_rsp_en !== 2'b00) begin bad++; $display("FAIL err_no_rsp: got %b required 00", c_rsp_en); end
    total++; if (err_unexpected_rsp !== 1'b1) begin bad++; $display("FAIL err_set: got %b required 1", err_unexpected_rsp); end
    for (int i = 0; i < 5; i++) step();
    total++; if (err_unexpected_rsp !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b required 1", err_unexpected_rsp); end
  endtask

  task automatic test_reset_midflight();
    int   n;
    logic got;
    t_srv s;
    issue_one(1, 36'h0_0000_0D01, 8'hD1, 4'h1);
    issue_one(1, 36'h0_0000_0D02, 8'hD2, 4'h2);
    issue_one(0, 36'h0_0000_0D03, 8'hD3, 4'h3);
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b required 0", busy); end
    total++; if (srv_reqEn !== 1'b0) begin bad++; $display("FAIL mid_reqEn: got %b required 0", srv_reqEn); end
    total++; if (srv_reqVA !== 36'h0) begin bad++; $display("FAIL mid_reqVA: got %h required 0", srv_reqVA); end
    total++; if (c_rsp_en !== 2'b00) begin bad++; $display("FAIL mid_rsp_en: got %b required 00", c_rsp_en); end
    total++; if (c_rsp_pa !== 30'h0) begin bad++; $display("FAIL mid_rsp_pa: got %h required 0", c_rsp_pa); end
    total++; if (err_unexpected_rsp !== 1'b0) begin bad++; $display("FAIL mid_err: got %b required 0", err_unexpected_rsp); end
    srv_q.delete();
    exp_q.delete();
    step(); step();
    reset_n = 1'b1;
    step();
    cva[0] = 36'h0_0000_0E00; cmeta[0] = 8'hE0; ctag[0] = 4'h0;
    cva[1] = 36'h0_0000_0E01; cmeta[1] = 8'hE1; ctag[1] = 4'h1;
    c_req_valid = 2'b11;
    n = 0; got = 1'b0;
    #1;
    while (!got && n < 20) begin
      if (c_req_rdy != 2'b00) got = 1'b1;
      else begin @(posedge clk); #2; n++; end
    end
    total++;
    if (c_req_rdy !== 2'b01) begin
      bad++;
      $display("FAIL mid_first_grant: c_req_rdy=%b required 01", c_req_rdy);
    end
    step();
    c_req_valid = 2'b00;
    s.idx = 0; s.va = cva[0]; s.meta = cmeta[0]; s.tag = ctag[0];
    srv_q.push_back(s);
    step(); step();
    respond_next(30'h0000_5555);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_routing();
    test_backpressure();
    test_error();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
